bram_byte_loader: RTL and testbench
===================================

Name: bram_byte_loader

Overview:
- Upstream feeder for the 3-lane 24-bit dual-port BRAM.
- Accepts an 8-bit byte stream (valid/ready), packs N bytes little-endian into one DW+1-bit word and issues one write per word on a single BRAM port.
- Addresses increment from a base address and wrap at DP-1.
- Used for runtime loading (UART/SPI byte source) in place of, or on top of, the hex init files.

Parameters:
- DP, 512: BRAM depth in words.
- N, 3: bytes per word (number of 8-bit lanes).
- AW, $clog2(DP)-1: address MSB index.
- DW, N*8-1: data MSB index.
- BASE_ADDR, 0: first write address of each load.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- len  in  AW+2  words to load; 0 = empty load; values > DP saturate to DP.
- s_data  in  8  byte stream data.
- s_valid  in  1  byte stream valid.
- s_ready  out  1  byte stream ready.
- wr  out  1  BRAM write strobe (drives wra or wrb).
- addr  out  AW+1  BRAM word address.
- din  out  DW+1  BRAM write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at end of load.
- csum  out  8  running byte checksum (optional feature).

Behaviour:
- Reset (sync, active-high): state=IDLE; s_ready=0, wr=0, addr=BASE_ADDR, din=0, busy=0, done=0, csum=0. Internal byte/word counters cleared.
- Reset mid-load: return to IDLE at the next edge. No further wr, no done pulse, partial word discarded; already-written words stay in the BRAM.
- All outputs are registered.
- States:
  - IDLE: s_ready=0, busy=0. start=1 with len>0 -> LOAD; latch saturated len, word_cnt=0, lane=0, next address=BASE_ADDR. start=1 with len=0 -> stay IDLE, done=1 next cycle. start while busy is ignored.
  - LOAD: s_ready=1, busy=1.
    - Each accepted byte (s_valid & s_ready) goes to word lane `lane`: lane 0 -> bits 7:0, lane 1 -> bits 15:8, ..., lane N-1 -> bits DW:DW-7.
    - lane counts 0..N-1 and wraps.
    - Accepting lane N-1: next cycle wr=1 for exactly one cycle, din=assembled word, addr=current word address. Then word address increments, wrapping DP-1 -> 0 (modulo DP; BASE_ADDR+len may wrap). word_cnt increments.
    - The pack register is double-buffered, so bytes of the next word are accepted in the same cycle as a write. Sustained rate is 1 byte/cycle with no stall.
    - Final byte of word len -> LAST.
  - LAST: s_ready=0, wr=1 (final word), busy=1 -> DONE.
  - DONE: wr=0, busy=0, done=1 for one cycle -> IDLE.
- Latency: final byte accepted at cycle t; final wr at t+1; done at t+2, with busy=0 at t+2.
- s_valid gaps are allowed anywhere; lane state holds.
- Bytes offered while s_ready=0 are not consumed.
- Write address is not reset to BASE_ADDR until the next start.

Optional Feature:
- BRAM_BYTE_LOADER_CKSUM_EN defined: csum is an 8-bit modulo-256 sum of every accepted byte. Cleared on start and on rst; held after done until the next start.
- Not defined: csum tied to 0 and no adder is synthesized.

Decomposition:
- Shared package bram_pkg:
  - lane width constant (8);
  - state enum {IDLE, LOAD, LAST, DONE};
  - len-saturation helper function;
  - DP/N defaults shared with the BRAM wrapper.
- One natural sub-module: byte_packer (lane counter + double-buffered pack register, outputs word and word_valid pulse). The loader FSM plus address/word counters sit on top of it.

Test Plan:
- Reset, then start with len=2 and bytes 11,22,33,44,55,66 back-to-back -> wr at addr 0 with din=0x332211, wr at addr 1 with din=0x665544; done 2 cycles after byte 66; BRAM readback on port B matches.
- Random s_valid gaps (50%) with len=4 -> same data/addresses as the gapless run; exactly 4 wr pulses; done once.
- BASE_ADDR=510, DP=512, len=3 -> writes to 510, 511, 0 in order.
- start with len=0 -> no wr, s_ready never high, done=1 one cycle later; start while busy -> ignored, no length relatch.
- rst asserted after 4 of 6 bytes (len=2) -> only the addr-0 write occurred, no done, all outputs at reset values next cycle; a new start loads cleanly.
- With BRAM_BYTE_LOADER_CKSUM_EN, bytes FF,02,03 -> csum=0x04; without the macro, csum=0 throughout.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: definitions shared by the BRAM wrapper and its byte loader.
//   LANE_W   : width of one byte lane of a BRAM word
//   BRAM_DP  : default BRAM depth in words
//   BRAM_N   : default number of byte lanes per word
//   load_state_t : loader FSM states
//   sat_len  : clamps a requested load length to the BRAM depth
package bram_pkg;

   localparam int unsigned LANE_W  = 8;
   localparam int unsigned BRAM_DP = 512;
   localparam int unsigned BRAM_N  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } load_state_t;

   // A load can never usefully write more words than the BRAM holds.
   function automatic int unsigned sat_len(input int unsigned len, input int unsigned dp);
      return (len > dp) ? dp : len;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs a byte stream little-endian into N-lane words.
// The word output register is separate from the accumulating pack
// register, so the first byte of the next word can be taken in the
// same cycle the previous word is presented.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart at lane 0 (new load)
//   data       : byte in
//   valid      : byte accepted this cycle
//   lane       : lane the next accepted byte lands in
//   word       : assembled word (held until the next word completes)
//   word_valid : one-cycle pulse, cycle after the last lane is accepted
module byte_packer
   import bram_pkg::*;
#(
   parameter int unsigned N  = BRAM_N,
   parameter int unsigned WW = N * LANE_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic [LANE_W-1:0]       data,
   input  logic                    valid,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] lane,
   output logic [WW-1:0]           word,
   output logic                    word_valid
);

   localparam int unsigned LNW = (N > 1) ? $clog2(N) : 1;

   logic [WW-1:0] pack_q;
   logic [WW-1:0] word_c;

   // Completed word: earlier lanes from the pack register, top lane straight from the input.
   always_comb begin
      word_c = pack_q;
      word_c[WW-LANE_W +: LANE_W] = data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane       <= '0;
         pack_q     <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clr) begin
            lane <= '0;
         end else if (valid) begin
            for (int i = 0; i < int'(N); i++) begin
               if (lane == LNW'(i)) pack_q[i*LANE_W +: LANE_W] <= data;
            end
            if (lane == LNW'(N-1)) begin
               lane       <= '0;
               word       <= word_c;
               word_valid <= 1'b1;
            end else begin
               lane <= lane + LNW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/bram_byte_loader.sv
// bram_byte_loader: loads a byte stream into a BRAM through one write port.
// N bytes are packed little-endian per word; words are written from
// BASE_ADDR upward, wrapping modulo DP.
// Optional feature macro: BRAM_BYTE_LOADER_CKSUM_EN enables the running
// modulo-256 byte checksum on csum; otherwise csum is constant 0.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : load request (sampled only in IDLE), len = words to load
//   s_data, s_valid, s_ready : byte stream
//   wr, addr, din : BRAM write port
//   busy     : load in progress
//   done     : one-cycle end-of-load pulse
//   csum     : running byte checksum
module bram_byte_loader
   import bram_pkg::*;
#(
   parameter int unsigned DP        = BRAM_DP,
   parameter int unsigned N         = BRAM_N,
   parameter int unsigned AW        = $clog2(DP) - 1,
   parameter int unsigned DW        = N * LANE_W - 1,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW+1:0] len,
   input  logic [7:0]    s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          wr,
   output logic [AW:0]   addr,
   output logic [DW:0]   din,
   output logic          busy,
   output logic          done,
   output logic [7:0]    csum
);

   localparam int unsigned LW  = AW + 2;
   localparam int unsigned AWD = AW + 1;
   localparam int unsigned LNW = (N > 1) ? $clog2(N) : 1;

   load_state_t    state;
   logic [LW-1:0]  len_q;
   logic [LW-1:0]  word_cnt;
   logic [LW-1:0]  len_sat;
   logic [LNW-1:0] lane;
   logic [AW:0]    next_addr;
   logic           accept;
   logic           clr;
   logic           last_lane;

   assign accept    = s_valid & s_ready;
   assign clr       = (state == IDLE) & start;
   assign last_lane = (lane == LNW'(N-1));
   assign len_sat   = LW'(sat_len(32'(len), DP));
   assign next_addr = (addr == AWD'(DP-1)) ? '0 : addr + AWD'(1);

   byte_packer #(
      .N  (N),
      .WW (DW+1)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .data       (s_data),
      .valid      (accept),
      .lane       (lane),
      .word       (din),
      .word_valid (wr)
   );

   // Loader FSM; wr/din come registered from the packer, addr advances after each write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         s_ready  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         len_q    <= '0;
         word_cnt <= '0;
         addr     <= AWD'(BASE_ADDR);
      end else begin
         done <= 1'b0;
         if (wr) addr <= next_addr;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (len_sat != '0) begin
                     state    <= LOAD;
                     s_ready  <= 1'b1;
                     busy     <= 1'b1;
                     len_q    <= len_sat;
                     word_cnt <= '0;
                     addr     <= AWD'(BASE_ADDR);
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept && last_lane) begin
                  word_cnt <= word_cnt + LW'(1);
                  if (word_cnt == len_q - LW'(1)) begin
                     state   <= LAST;
                     s_ready <= 1'b0;
                  end
               end
            end
            LAST: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BRAM_BYTE_LOADER_CKSUM_EN
   // Modulo-256 sum of accepted bytes, restarted by each load request.
   always_ff @(posedge clk) begin
      if (rst)         csum <= '0;
      else if (clr)    csum <= '0;
      else if (accept) csum <= csum + s_data;
   end
`else
   assign csum = '0;
`endif

endmodule

// File: tb/tb_bram_byte_loader.sv
// tb_bram_byte_loader: scoreboard bench for bram_byte_loader.
// dut0 loads from address 0, dut1 from 510 to exercise the address wrap.
module tb_bram_byte_loader;

   localparam int unsigned DP = 512;

   typedef struct {
      logic [8:0]  a;
      logic [23:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [9:0]  len = '0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;

   logic        s_ready0, wr0, busy0, done0;
   logic [8:0]  addr0;
   logic [23:0] din0;
   logic [7:0]  csum0;
   logic        s_ready1, wr1, busy1, done1;
   logic [8:0]  addr1;
   logic [23:0] din1;
   logic [7:0]  csum1;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_acc = 0;
   int wr0_cnt = 0, wr1_cnt = 0, done0_cnt = 0, done1_cnt = 0;
   int wr0_t = 0, done0_t = 0;
   logic done0_busy = 1'b0;

   wr_t exp0_q[$];
   wr_t exp1_q[$];
   wr_t e0, e1;
   logic [23:0] mem0 [DP];
   logic [23:0] mem1 [DP];

   bram_byte_loader #(.DP(512), .N(3), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .len(len),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
      .wr(wr0), .addr(addr0), .din(din0),
      .busy(busy0), .done(done0), .csum(csum0)
   );

   bram_byte_loader #(.DP(512), .N(3), .BASE_ADDR(510)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .len(len),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
      .wr(wr1), .addr(addr1), .din(din1),
      .busy(busy1), .done(done1), .csum(csum1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every write pops the oldest expected write; writes also update the BRAM model.
   always @(negedge clk) begin
      if (wr0) begin
         wr0_cnt++;
         wr0_t = cyc;
         mem0[addr0] = din0;
         n_cmp++;
         if (exp0_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr0_unexpected: got addr=%0d din=%h, required no write", addr0, din0);
         end else begin
            e0 = exp0_q.pop_front();
            if (addr0 !== e0.a || din0 !== e0.d) begin
               n_fail++;
               $display("FAIL wr0_data: got addr=%0d din=%h, required addr=%0d din=%h",
                        addr0, din0, e0.a, e0.d);
            end
         end
      end
      if (wr1) begin
         wr1_cnt++;
         mem1[addr1] = din1;
         n_cmp++;
         if (exp1_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr1_unexpected: got addr=%0d din=%h, required no write", addr1, din1);
         end else begin
            e1 = exp1_q.pop_front();
            if (addr1 !== e1.a || din1 !== e1.d) begin
               n_fail++;
               $display("FAIL wr1_data: got addr=%0d din=%h, required addr=%0d din=%h",
                        addr1, din1, e1.a, e1.d);
            end
         end
      end
      if (done0) begin
         done0_cnt++;
         done0_t    = cyc;
         done0_busy = busy0;
      end
      if (done1) done1_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_load(input bit which, input int n);
      len = 10'(n);
      if (which) start1 = 1'b1;
      else       start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Offers one byte (with optional random leading gaps) until it is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard = 0;
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      while (!(s_ready0 || s_ready1)) begin
         @(negedge clk);
         guard++;
         if (guard > 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles, required 1", guard);
            s_valid = 1'b0;
            return;
         end
      end
      last_acc = cyc;
      @(negedge clk);
   endtask

   // Streams bytes, pushing the expected write as each word's last byte goes out.
   task automatic send_bytes(input bit which, input int base, input logic [7:0] b[$], input int gap);
      wr_t w;
      for (int i = 0; i < b.size(); i++) begin
         if (i % 3 == 2) begin
            w.a = 9'((base + i / 3) % DP);
            w.d = {b[i], b[i-1], b[i-2]};
            if (which) exp1_q.push_back(w);
            else       exp0_q.push_back(w);
         end
         send_byte(b[i], gap);
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      idle(3);
      n_cmp++;
      if ({s_ready0, wr0, busy0, done0} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl0: got {s_ready,wr,busy,done}=%b, required 0000", {s_ready0, wr0, busy0, done0});
      end
      n_cmp++;
      if (addr0 !== 9'd0 || din0 !== 24'd0) begin
         n_fail++;
         $display("FAIL reset_port0: got addr=%0d din=%h, required addr=0 din=0", addr0, din0);
      end
      n_cmp++;
      if (addr1 !== 9'd510 || {s_ready1, wr1, busy1, done1} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_dut1: got addr=%0d ctrl=%b, required addr=510 ctrl=0000",
                  addr1, {s_ready1, wr1, busy1, done1});
      end
      n_cmp++;
      if (csum0 !== 8'd0 || csum1 !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_csum: got %h/%h, required 00/00", csum0, csum1);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[$];
      int w0 = wr0_cnt;
      int d0 = done0_cnt;
      b = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      start_load(1'b0, 2);
      send_bytes(1'b0, 0, b, 0);
      idle(4);
      n_cmp++;
      if (wr0_cnt - w0 != 2 || done0_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL b2b_counts: got wr=%0d done=%0d, required wr=2 done=1", wr0_cnt - w0, done0_cnt - d0);
      end
      n_cmp++;
      if (done0_t - last_acc != 2 || done0_t - wr0_t != 1) begin
         n_fail++;
         $display("FAIL b2b_latency: got done-lastbyte=%0d done-wr=%0d, required 2 and 1",
                  done0_t - last_acc, done0_t - wr0_t);
      end
      n_cmp++;
      if (done0_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_busy_at_done: got %b, required 0", done0_busy);
      end
      n_cmp++;
      if (mem0[0] !== 24'h332211 || mem0[1] !== 24'h665544) begin
         n_fail++;
         $display("FAIL b2b_readback: got %h %h, required 332211 665544", mem0[0], mem0[1]);
      end
      n_cmp++;
      if (addr0 !== 9'd2) begin
         n_fail++;
         $display("FAIL b2b_addr_hold: got %0d, required 2", addr0);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] b[$];
      int w0 = wr0_cnt;
      int d0 = done0_cnt;
      for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
      start_load(1'b0, 4);
      send_bytes(1'b0, 0, b, 50);
      idle(4);
      n_cmp++;
      if (wr0_cnt - w0 != 4 || done0_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL gaps_counts: got wr=%0d done=%0d, required wr=4 done=1", wr0_cnt - w0, done0_cnt - d0);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (mem0[k] !== {b[3*k+2], b[3*k+1], b[3*k]}) begin
            n_fail++;
            $display("FAIL gaps_readback[%0d]: got %h, required %h", k, mem0[k], {b[3*k+2], b[3*k+1], b[3*k]});
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] b[$];
      int w1 = wr1_cnt;
      int d1 = done1_cnt;
      for (int i = 0; i < 9; i++) b.push_back(8'(8'hA0 + i));
      start_load(1'b1, 3);
      send_bytes(1'b1, 510, b, 0);
      idle(4);
      n_cmp++;
      if (wr1_cnt - w1 != 3 || done1_cnt - d1 != 1 || exp1_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_counts: got wr=%0d done=%0d pending=%0d, required 3 1 0",
                  wr1_cnt - w1, done1_cnt - d1, exp1_q.size());
      end
      n_cmp++;
      if (mem1[510] !== 24'hA2A1A0 || mem1[511] !== 24'hA5A4A3 || mem1[0] !== 24'hA8A7A6) begin
         n_fail++;
         $display("FAIL wrap_readback: got %h %h %h, required a2a1a0 a5a4a3 a8a7a6", mem1[510], mem1[511], mem1[0]);
      end
      n_cmp++;
      if (addr1 !== 9'd1) begin
         n_fail++;
         $display("FAIL wrap_addr_hold: got %0d, required 1", addr1);
      end
   endtask

   task automatic test_zero_len();
      int w0 = wr0_cnt;
      int d0 = done0_cnt;
      logic rdy_seen = 1'b0;
      start_load(1'b0, 0);
      n_cmp++;
      if (done0 !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_done: got done=%b busy=%b, required done=1 busy=0", done0, busy0);
      end
      for (int i = 0; i < 5; i++) begin
         if (s_ready0) rdy_seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++;
      if (rdy_seen !== 1'b0 || wr0_cnt != w0 || done0_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL zero_quiet: got ready_seen=%b wr=%0d done=%0d, required 0 0 1",
                  rdy_seen, wr0_cnt - w0, done0_cnt - d0);
      end
   endtask

   task automatic test_start_busy();
      logic [7:0] b[$];
      int w0 = wr0_cnt;
      int d0 = done0_cnt;
      b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      start_load(1'b0, 2);
      len    = 10'd5;
      start0 = 1'b1;
      idle(1);
      start0 = 1'b0;
      send_bytes(1'b0, 0, b, 0);
      idle(4);
      n_cmp++;
      if (wr0_cnt - w0 != 2 || done0_cnt - d0 != 1 || done0_t - last_acc != 2) begin
         n_fail++;
         $display("FAIL busy_start_ignored: got wr=%0d done=%0d latency=%0d, required 2 1 2",
                  wr0_cnt - w0, done0_cnt - d0, done0_t - last_acc);
      end
      n_cmp++;
      if (s_ready0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_no_relatch: got s_ready=%b busy=%b, required 0 0", s_ready0, busy0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[$];
      logic [7:0] c[$];
      int w0 = wr0_cnt;
      int d0 = done0_cnt;
      b = {8'h11, 8'h22, 8'h33, 8'h44};
      c = {8'hAA, 8'hBB, 8'hCC};
      start_load(1'b0, 2);
      send_bytes(1'b0, 0, b, 0);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({s_ready0, wr0, busy0, done0} !== 4'b0 || addr0 !== 9'd0 || din0 !== 24'd0 || csum0 !== 8'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got ctrl=%b addr=%0d din=%h csum=%h, required 0000 0 0 0",
                  {s_ready0, wr0, busy0, done0}, addr0, din0, csum0);
      end
      rst = 1'b0;
      idle(3);
      n_cmp++;
      if (wr0_cnt - w0 != 1 || done0_cnt != d0 || mem0[0] !== 24'h332211) begin
         n_fail++;
         $display("FAIL midrst_writes: got wr=%0d done=%0d mem0=%h, required 1 0 332211",
                  wr0_cnt - w0, done0_cnt - d0, mem0[0]);
      end
      start_load(1'b0, 1);
      send_bytes(1'b0, 0, c, 0);
      idle(4);
      n_cmp++;
      if (wr0_cnt - w0 != 2 || done0_cnt - d0 != 1 || mem0[0] !== 24'hCCBBAA) begin
         n_fail++;
         $display("FAIL midrst_reload: got wr=%0d done=%0d mem0=%h, required 2 1 ccbbaa",
                  wr0_cnt - w0, done0_cnt - d0, mem0[0]);
      end
   endtask

   task automatic test_cksum();
      logic [7:0] b[$];
      logic [7:0] exp_sum;
      b = {8'hFF, 8'h02, 8'h03};
`ifdef BRAM_BYTE_LOADER_CKSUM_EN
      exp_sum = 8'hFF + 8'h02 + 8'h03;
`else
      exp_sum = 8'h00;
`endif
      start_load(1'b0, 1);
      send_bytes(1'b0, 0, b, 0);
      idle(4);
      n_cmp++;
      if (csum0 !== exp_sum) begin
         n_fail++;
         $display("FAIL cksum_value: got %h, required %h", csum0, exp_sum);
      end
      idle(3);
      n_cmp++;
      if (csum0 !== exp_sum) begin
         n_fail++;
         $display("FAIL cksum_hold: got %h, required %h", csum0, exp_sum);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DP); i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      test_reset();
      test_back_to_back();
      test_gaps();
      test_wrap();
      test_zero_len();
      test_start_busy();
      test_reset_mid();
      test_cksum();
      n_cmp++;
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_writes: got %0d/%0d outstanding, required 0/0", exp0_q.size(), exp1_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
